// File: rtl/miriscv_mem_arbiter.sv
// rtl/miriscv_mem_arbiter.sv - fetch/load-store arbiter onto a single-outstanding memory port.
// Optional: define MIRISCV_ARB_ROUND_ROBIN_EN for alternating priority instead of fixed data priority.

package miriscv_pkg;
  parameter int XLEN = 32;
endpackage

module miriscv_mem_arbiter #(
  parameter int XLEN = miriscv_pkg::XLEN
) (
  input  logic            clk_i,
  input  logic            arstn_i,

  input  logic            instr_req_i,
  input  logic [XLEN-1:0] instr_addr_i,
  output logic            instr_gnt_o,
  output logic            instr_rvalid_o,
  output logic [XLEN-1:0] instr_rdata_o,
  input  logic            instr_kill_i,

  input  logic            data_req_i,
  input  logic            data_we_i,
  input  logic [3:0]      data_be_i,
  input  logic [XLEN-1:0] data_addr_i,
  input  logic [XLEN-1:0] data_wdata_i,
  output logic            data_gnt_o,
  output logic            data_rvalid_o,
  output logic [XLEN-1:0] data_rdata_o,

  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [3:0]      mem_be_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_I = 2'd1,
    WAIT_D = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic            r_we;
  logic [3:0]      r_be;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;

  logic            w_idle;
  logic            w_instr_req;
  logic            w_prio_d;
  logic            w_sel_d;
  logic            w_req;
  logic            w_accept;
  logic            w_we;
  logic [3:0]      w_be;
  logic [XLEN-1:0] w_addr;
  logic [XLEN-1:0] w_wdata;

  // A killed fetch never reaches the memory, so it cannot be accepted without a grant.
  assign w_idle      = (r_state == IDLE);
  assign w_instr_req = instr_req_i & ~instr_kill_i;

`ifdef MIRISCV_ARB_ROUND_ROBIN_EN
  logic r_prio_d;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_prio_d <= 1'b1;
    end else if (w_accept) begin
      r_prio_d <= ~w_sel_d;
    end
  end

  assign w_prio_d = r_prio_d;
`else
  assign w_prio_d = 1'b1;
`endif

  assign w_sel_d  = data_req_i & (~w_instr_req | w_prio_d);
  assign w_req    = w_idle & (w_instr_req | data_req_i);
  assign w_accept = w_req & mem_gnt_i;

  always_comb begin
    w_we    = 1'b0;
    w_be    = 4'hf;
    w_addr  = instr_addr_i;
    w_wdata = '0;
    if (w_sel_d) begin
      w_we    = data_we_i;
      w_be    = data_be_i;
      w_addr  = data_addr_i;
      w_wdata = data_wdata_i;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_sel_d ? WAIT_D : WAIT_I;
        end
      end
      WAIT_I: begin
        if (mem_rvalid_i) begin
          w_state_nxt = IDLE;
        end else if (instr_kill_i) begin
          w_state_nxt = DRAIN;
        end
      end
      WAIT_D: begin
        if (mem_rvalid_i) begin
          w_state_nxt = IDLE;
        end
      end
      DRAIN: begin
        if (mem_rvalid_i) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Issued request fields are held on the bus while the transaction is outstanding.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_we    <= 1'b0;
      r_be    <= 4'h0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_we    <= w_we;
      r_be    <= w_be;
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
    end
  end

  assign mem_req_o   = arstn_i & w_req;
  assign mem_we_o    = arstn_i & (w_idle ? w_we : r_we);
  assign mem_be_o    = arstn_i ? (w_idle ? w_be    : r_be)    : 4'h0;
  assign mem_addr_o  = arstn_i ? (w_idle ? w_addr  : r_addr)  : '0;
  assign mem_wdata_o = arstn_i ? (w_idle ? w_wdata : r_wdata) : '0;

  assign instr_gnt_o = arstn_i & w_accept & ~w_sel_d;
  assign data_gnt_o  = arstn_i & w_accept &  w_sel_d;

  assign instr_rvalid_o = arstn_i & (r_state == WAIT_I) & mem_rvalid_i & ~instr_kill_i;
  assign data_rvalid_o  = arstn_i & (r_state == WAIT_D) & mem_rvalid_i;

  assign instr_rdata_o = mem_rdata_i;
  assign data_rdata_o  = mem_rdata_i;

endmodule

// File: tb/tb_miriscv_mem_arbiter.sv
// tb/tb_miriscv_mem_arbiter.sv - directed self-checking bench for miriscv_mem_arbiter.
module tb_miriscv_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        arstn_i;
  logic        instr_req_i, instr_kill_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o, instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i, data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i, data_wdata_i;
  logic        data_gnt_o, data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  miriscv_mem_arbiter dut (
    .clk_i(clk_i), .arstn_i(arstn_i),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
    .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
    .instr_kill_i(instr_kill_i),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
  task automatic nxt();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    instr_req_i = 0; instr_kill_i = 0; instr_addr_i = '0;
    data_req_i = 0; data_we_i = 0; data_be_i = 4'h0; data_addr_i = '0; data_wdata_i = '0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
  endtask

  initial begin
    idle_inputs();
    arstn_i = 0;
    instr_req_i = 1; instr_addr_i = 32'h100; data_req_i = 1; mem_gnt_i = 1;
    #3;
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_instr_gnt", instr_gnt_o, 0);
    chk("rst_data_gnt", data_gnt_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    nxt(); nxt();
    idle_inputs();
    arstn_i = 1;

    // Fetch 0x100, response two cycles after the grant.
    nxt(); instr_req_i = 1; instr_addr_i = 32'h100; mem_gnt_i = 1; settle();
    chk("f_mem_req", mem_req_o, 1);
    chk("f_mem_addr", mem_addr_o, 32'h100);
    chk("f_mem_we", mem_we_o, 0);
    chk("f_igno", instr_gnt_o, 1);
    chk("f_dgnt", data_gnt_o, 0);
    nxt(); instr_req_i = 0; mem_gnt_i = 0; settle();
    chk("f_wait_req", mem_req_o, 0);
    chk("f_wait_gnt", instr_gnt_o, 0);
    chk("f_hold_addr", mem_addr_o, 32'h100);
    nxt(); mem_rvalid_i = 1; mem_rdata_i = 32'h13; settle();
    chk("f_irvalid", instr_rvalid_o, 1);
    chk("f_irdata", instr_rdata_o, 32'h13);
    chk("f_drvalid", data_rvalid_o, 0);
    nxt(); mem_rvalid_i = 0; settle();
    chk("f_irvalid_off", instr_rvalid_o, 0);

    // Conflict: data wins, fetch granted once the data response has returned.
    nxt(); instr_req_i = 1; instr_addr_i = 32'h200; data_req_i = 1; data_addr_i = 32'h8000;
    mem_gnt_i = 1; settle();
    chk("c_dgnt", data_gnt_o, 1);
    chk("c_igno", instr_gnt_o, 0);
    chk("c_addr", mem_addr_o, 32'h8000);
    nxt(); data_req_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hAAAA5555; settle();
    chk("c_drvalid", data_rvalid_o, 1);
    chk("c_drdata", data_rdata_o, 32'hAAAA5555);
    chk("c_irvalid", instr_rvalid_o, 0);
    chk("c_resp_igno", instr_gnt_o, 0);
    chk("c_resp_req", mem_req_o, 0);
    nxt(); mem_rvalid_i = 0; settle();
    chk("c_igno2", instr_gnt_o, 1);
    chk("c_addr2", mem_addr_o, 32'h200);
    nxt(); instr_req_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h1234; settle();
    chk("c_irvalid2", instr_rvalid_o, 1);
    nxt(); idle_inputs();

    // Write with partial byte enables.
    nxt(); data_req_i = 1; data_we_i = 1; data_be_i = 4'b0011; data_addr_i = 32'h8004;
    data_wdata_i = 32'hDEADBEEF; mem_gnt_i = 1; settle();
    chk("w_dgnt", data_gnt_o, 1);
    chk("w_we", mem_we_o, 1);
    chk("w_be", mem_be_o, 4'b0011);
    chk("w_wdata", mem_wdata_o, 32'hDEADBEEF);
    chk("w_addr", mem_addr_o, 32'h8004);
    nxt(); data_req_i = 0; data_we_i = 0; data_be_i = 0; data_wdata_i = 0; mem_rvalid_i = 1; settle();
    chk("w_hold_we", mem_we_o, 1);
    chk("w_hold_be", mem_be_o, 4'b0011);
    chk("w_drvalid", data_rvalid_o, 1);
    chk("w_irvalid", instr_rvalid_o, 0);
    nxt(); mem_rvalid_i = 0; settle();
    chk("w_drvalid_off", data_rvalid_o, 0);
    idle_inputs();

    // Fetch killed after acceptance: drain, pending data waits for the drain.
    nxt(); instr_req_i = 1; instr_addr_i = 32'h300; mem_gnt_i = 1; settle();
    chk("k_igno", instr_gnt_o, 1);
    nxt(); instr_req_i = 0; instr_kill_i = 1; data_req_i = 1; data_addr_i = 32'h9000; settle();
    chk("k_dgnt0", data_gnt_o, 0);
    chk("k_req0", mem_req_o, 0);
    for (int i = 0; i < 2; i++) begin
      nxt(); instr_kill_i = 0; settle();
      chk("k_drain_dgnt", data_gnt_o, 0);
      chk("k_drain_req", mem_req_o, 0);
    end
    nxt(); mem_rvalid_i = 1; mem_rdata_i = 32'h77; settle();
    chk("k_irvalid", instr_rvalid_o, 0);
    chk("k_drvalid", data_rvalid_o, 0);
    chk("k_dgnt_resp", data_gnt_o, 0);
    nxt(); mem_rvalid_i = 0; settle();
    chk("k_dgnt", data_gnt_o, 1);
    chk("k_daddr", mem_addr_o, 32'h9000);
    nxt(); data_req_i = 0; mem_rvalid_i = 1; settle();
    chk("k_drvalid2", data_rvalid_o, 1);
    nxt(); idle_inputs();

    // Kill coincident with the response, then kill in IDLE.
    nxt(); instr_req_i = 1; instr_addr_i = 32'h340; mem_gnt_i = 1; settle();
    chk("kc_igno", instr_gnt_o, 1);
    nxt(); instr_req_i = 0; instr_kill_i = 1; mem_rvalid_i = 1; settle();
    chk("kc_irvalid", instr_rvalid_o, 0);
    nxt(); mem_rvalid_i = 0; instr_req_i = 1; data_req_i = 1; data_addr_i = 32'h9100; settle();
    chk("ki_igno", instr_gnt_o, 0);
    chk("ki_dgnt", data_gnt_o, 1);
    nxt(); instr_req_i = 0; instr_kill_i = 0; data_req_i = 0; mem_rvalid_i = 1; settle();
    chk("ki_drvalid", data_rvalid_o, 1);
    nxt(); idle_inputs();

    // Memory stalls the grant for four cycles.
    nxt(); instr_req_i = 1; instr_addr_i = 32'h400; mem_gnt_i = 0;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("s_req", mem_req_o, 1);
      chk("s_addr", mem_addr_o, 32'h400);
      chk("s_igno", instr_gnt_o, 0);
      nxt();
    end
    mem_gnt_i = 1; settle();
    chk("s_igno_go", instr_gnt_o, 1);
    nxt(); instr_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; settle();
    chk("s_irvalid", instr_rvalid_o, 1);
    nxt(); idle_inputs();

    // Reset while a data read is outstanding, then a stray response.
    nxt(); data_req_i = 1; data_addr_i = 32'h8800; mem_gnt_i = 1; settle();
    chk("r_dgnt", data_gnt_o, 1);
    nxt(); data_req_i = 0; arstn_i = 0; settle();
    chk("r_mem_req", mem_req_o, 0);
    chk("r_mem_addr", mem_addr_o, 0);
    chk("r_drvalid", data_rvalid_o, 0);
    nxt(); arstn_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'h55; settle();
    chk("r_stray_drvalid", data_rvalid_o, 0);
    chk("r_stray_irvalid", instr_rvalid_o, 0);
    chk("r_idle_addr", mem_addr_o, 0);
    nxt(); mem_rvalid_i = 0; instr_req_i = 1; instr_addr_i = 32'h500; settle();
    chk("r_idle_igno", instr_gnt_o, 1);
    nxt(); instr_req_i = 0; mem_rvalid_i = 1; settle();
    chk("r_irvalid", instr_rvalid_o, 1);
    nxt(); idle_inputs();

    nxt();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
